// File: rtl/battleship_pkg.sv
// Shared constants for the battleship VGA display path: grid geometry,
// cell-state encoding, visible raster size and the cell address helper.
package battleship_pkg;

  localparam int GRID_N    = 10;
  localparam int CELL_PX   = 32;
  localparam int CELL_LOG2 = $clog2(CELL_PX);
  localparam int GRID_PX   = GRID_N * CELL_PX;
  localparam int ADDR_W    = 7;
  localparam int IDX_W     = $clog2(GRID_N);

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_V_VISIBLE = 480;

  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'b00,  // no ship, not shot
    CELL_MISS     = 2'b01,  // no ship, shot
    CELL_SHIP     = 2'b10,  // ship, not shot
    CELL_SHIP_HIT = 2'b11   // ship, shot
  } cell_state_e;

  // Row-major cell address; the result always fits because rows/cols < GRID_N.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    return ADDR_W'(int'(row) * GRID_N + int'(col));
  endfunction

endpackage

// File: rtl/grid_locator.sv
// Single-axis grid locator: maps a raster coordinate to a cell index and
// flags whether it lies inside the grid span starting at origin.
// With GRID_LINES_EN defined it also reports the first pixel of each cell.
module grid_locator
  import battleship_pkg::*;
(
  input  logic [9:0]       pix,
  input  logic [9:0]       origin,
  output logic [IDX_W-1:0] index,
  output logic             in_range
`ifdef GRID_LINES_EN
  ,
  output logic             on_border
`endif
);

  logic [9:0]  delta;
  logic [10:0] span_end;

  // Range test is done on the raw coordinate in 11 bits so a pixel left of
  // the origin never wraps into a large, apparently valid index.
  always_comb begin
    delta    = pix - origin;
    span_end = {1'b0, origin} + 11'(GRID_PX);
    in_range = (pix >= origin) && ({1'b0, pix} < span_end);
    index    = IDX_W'(delta >> CELL_LOG2);
  end

`ifdef GRID_LINES_EN
  // Offset zero inside a cell is the one-pixel border line.
  always_comb begin
    on_border = (delta[CELL_LOG2-1:0] == '0);
  end
`endif

endmodule

// File: rtl/grid_fetch.sv
// grid_fetch: locates the current raster pixel in the placement or shooting
// grid, issues the cell memory read address, and returns the cell state with
// output enables two cycles later, sync delayed to stay aligned.
// Optional build macro GRID_LINES_EN: the first pixel row/column of every
// cell is treated as background so 1-pixel cell borders appear.
module grid_fetch
  import battleship_pkg::*;
#(
  parameter int PLACE_X0 = 64,
  parameter int SHOOT_X0 = 384,
  parameter int GRID_Y0  = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] Place_ADDR,
  output logic [ADDR_W-1:0] Shoot_ADDR,
  input  logic [1:0]        Place_RD_DATA,
  input  logic [1:0]        Shoot_RD_DATA,
  output logic [1:0]        Place_DATA,
  output logic [1:0]        Shoot_DATA,
  output logic              Place_OE,
  output logic              Shoot_OE,
  output logic              hsync_out,
  output logic              vsync_out
);

  logic [IDX_W-1:0]  place_col, shoot_col, grid_row;
  logic              place_x_in, shoot_x_in, y_in;
  logic              place_hit, shoot_hit;
  logic [ADDR_W-1:0] place_addr, shoot_addr;
  logic              place_hit_p0, shoot_hit_p0;
  logic              hsync_p0, vsync_p0;
  logic              border;

`ifdef GRID_LINES_EN
  logic place_x_border, shoot_x_border, y_border;
`endif

  grid_locator u_place_x (
    .pix      (pix_x),
    .origin   (10'(PLACE_X0)),
    .index    (place_col),
    .in_range (place_x_in)
`ifdef GRID_LINES_EN
    , .on_border (place_x_border)
`endif
  );

  grid_locator u_shoot_x (
    .pix      (pix_x),
    .origin   (10'(SHOOT_X0)),
    .index    (shoot_col),
    .in_range (shoot_x_in)
`ifdef GRID_LINES_EN
    , .on_border (shoot_x_border)
`endif
  );

  grid_locator u_grid_y (
    .pix      (pix_y),
    .origin   (10'(GRID_Y0)),
    .index    (grid_row),
    .in_range (y_in)
`ifdef GRID_LINES_EN
    , .on_border (y_border)
`endif
  );

  // Hit decode and address formation; placement wins if the regions overlap.
  always_comb begin
`ifdef GRID_LINES_EN
    border = y_border | (place_x_in ? place_x_border : shoot_x_border);
`else
    border = 1'b0;
`endif
    place_hit  = video_on & place_x_in & y_in & ~border;
    shoot_hit  = video_on & shoot_x_in & y_in & ~border & ~place_hit;
    place_addr = cell_addr(grid_row, place_col);
    shoot_addr = cell_addr(grid_row, shoot_col);
  end

  // ---- stage 0: read address out, hits and sync captured ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Place_ADDR   <= '0;
      Shoot_ADDR   <= '0;
      place_hit_p0 <= 1'b0;
      shoot_hit_p0 <= 1'b0;
      hsync_p0     <= 1'b1;
      vsync_p0     <= 1'b1;
    end else begin
      Place_ADDR   <= place_hit ? place_addr : '0;
      Shoot_ADDR   <= shoot_hit ? shoot_addr : '0;
      place_hit_p0 <= place_hit;
      shoot_hit_p0 <= shoot_hit;
      hsync_p0     <= hsync_in;
      vsync_p0     <= vsync_in;
    end
  end

  // ---- stage 1: memory data captured, gated by the delayed hits ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Place_DATA <= CELL_EMPTY;
      Shoot_DATA <= CELL_EMPTY;
      Place_OE   <= 1'b0;
      Shoot_OE   <= 1'b0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
    end else begin
      Place_DATA <= place_hit_p0 ? Place_RD_DATA : CELL_EMPTY;
      Shoot_DATA <= shoot_hit_p0 ? Shoot_RD_DATA : CELL_EMPTY;
      Place_OE   <= place_hit_p0;
      Shoot_OE   <= shoot_hit_p0;
      hsync_out  <= hsync_p0;
      vsync_out  <= vsync_p0;
    end
  end

endmodule

// File: tb/tb_grid_fetch.sv
// Scoreboard bench for grid_fetch. Directed pixel vectors push their
// hand-computed address and output expectations into queues; a monitor
// pops and compares when each expectation falls due. Honours GRID_LINES_EN.
module tb_grid_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [6:0] Place_ADDR, Shoot_ADDR;
  logic [1:0] Place_RD_DATA, Shoot_RD_DATA, Place_DATA, Shoot_DATA;
  logic       Place_OE, Shoot_OE, hsync_out, vsync_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [6:0] pa; logic [6:0] sa; } a_exp_t;
  typedef struct { int cyc; logic poe; logic soe; logic [1:0] pd; logic [1:0] sd; logic hs; logic vs; } o_exp_t;
  a_exp_t aq[$];
  o_exp_t oq[$];
  a_exp_t a_cur;
  o_exp_t o_cur;

  grid_fetch dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .Place_ADDR(Place_ADDR), .Shoot_ADDR(Shoot_ADDR),
    .Place_RD_DATA(Place_RD_DATA), .Shoot_RD_DATA(Shoot_RD_DATA),
    .Place_DATA(Place_DATA), .Shoot_DATA(Shoot_DATA),
    .Place_OE(Place_OE), .Shoot_OE(Shoot_OE),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: placement cell a holds (a+1)%4, shooting cell a holds 3-(a%4).
  assign Place_RD_DATA = 2'(Place_ADDR + 7'd1);
  assign Shoot_RD_DATA = ~Shoot_ADDR[1:0];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One input vector per cycle; expectations are queued with the issue cycle.
  task automatic drive(input int x, input int y, input logic von, input logic hs, input logic vs,
                       input int pa, input int sa, input logic poe, input logic soe,
                       input int pd, input int sd);
    a_exp_t ae;
    o_exp_t oe;
    @(posedge clk);
    #2;
    pix_x = 10'(x); pix_y = 10'(y); video_on = von; hsync_in = hs; vsync_in = vs;
    ae.cyc = cyc; ae.pa = 7'(pa); ae.sa = 7'(sa);
    oe.cyc = cyc; oe.poe = poe; oe.soe = soe; oe.pd = 2'(pd); oe.sd = 2'(sd);
    oe.hs = hs; oe.vs = vs;
    aq.push_back(ae);
    oq.push_back(oe);
  endtask

  // Grid vector; border marks a cell-edge pixel, which is background when
  // grid lines are enabled.
  task automatic vec(input int x, input int y, input logic von, input logic border,
                     input int pa, input int sa, input logic poe, input logic soe,
                     input int pd, input int sd);
`ifdef GRID_LINES_EN
    if (border) begin
      pa = 0; sa = 0; poe = 1'b0; soe = 1'b0; pd = 0; sd = 0;
    end
`endif
    drive(x, y, von, 1'b1, 1'b1, pa, sa, poe, soe, pd, sd);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_place_addr"}, 32'(Place_ADDR), 0);
    chk({tag, "_shoot_addr"}, 32'(Shoot_ADDR), 0);
    chk({tag, "_data"}, 32'({Place_DATA, Shoot_DATA}), 0);
    chk({tag, "_oe"}, 32'({Place_OE, Shoot_OE}), 0);
    chk({tag, "_sync"}, 32'({hsync_out, vsync_out}), 32'h3);
  endtask

  // Monitor: compares each queued expectation in the cycle it falls due.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aq.size() > 0 && aq[0].cyc + 1 <= cyc) begin
        a_cur = aq.pop_front();
        if (a_cur.cyc + 1 == cyc) begin
          chk("place_addr", 32'(Place_ADDR), 32'(a_cur.pa));
          chk("shoot_addr", 32'(Shoot_ADDR), 32'(a_cur.sa));
        end else begin
          checks++; failures++;
          $display("FAIL addr_missed: issued cycle %0d, now %0d", a_cur.cyc, cyc);
        end
      end
      if (oq.size() > 0 && oq[0].cyc + 2 <= cyc) begin
        o_cur = oq.pop_front();
        if (o_cur.cyc + 2 == cyc) begin
          chk("outputs{poe,soe,pd,sd,hs,vs}",
              32'({Place_OE, Shoot_OE, Place_DATA, Shoot_DATA, hsync_out, vsync_out}),
              32'({o_cur.poe, o_cur.soe, o_cur.pd, o_cur.sd, o_cur.hs, o_cur.vs}));
        end else begin
          checks++; failures++;
          $display("FAIL out_missed: issued cycle %0d, now %0d", o_cur.cyc, cyc);
        end
      end
      chk("oe_exclusive", 32'(Place_OE & Shoot_OE), 0);
    end
  end

  initial begin
    #(40 * 5000);
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with an active in-grid pixel.
    pix_x = 10'd165; pix_y = 10'd329; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    rst_n = 1'b1;

    //   x    y    von bdr pa  sa  poe  soe  pd sd
    vec(165, 329, 1'b1, 1'b0, 73,  0, 1'b1, 1'b0, 2, 0);  // col 3 row 7
    vec(383, 100, 1'b1, 1'b0,  9,  0, 1'b1, 1'b0, 2, 0);  // last placement col
    vec(384, 415, 1'b1, 1'b1,  0, 90, 1'b0, 1'b1, 0, 1);  // shoot col 0, last row
    vec(704, 329, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 0, 0);  // right of shooting grid
    vec(500, 416, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 0, 0);  // below grids
    vec(703, 415, 1'b1, 1'b0,  0, 99, 1'b0, 1'b1, 0, 0);  // last shooting cell
    vec(165, 329, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0, 0, 0);  // blanking
    vec( 63, 329, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 0, 0);  // left of placement, no wrap
    vec(165,  95, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 0, 0);  // above grids
    vec( 96, 165, 1'b1, 1'b1, 21,  0, 1'b1, 1'b0, 2, 0);  // cell boundary column
    vec( 97, 165, 1'b1, 1'b0, 21,  0, 1'b1, 1'b0, 2, 0);  // one past boundary
    vec(400, 200, 1'b1, 1'b0,  0, 30, 1'b0, 1'b1, 0, 1);
    vec(560, 230, 1'b1, 1'b0,  0, 45, 1'b0, 1'b1, 0, 2);
    vec( 64, 129, 1'b1, 1'b1, 10,  0, 1'b1, 1'b0, 3, 0);  // placement col 0
    vec(  0,   0, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 0, 0);

    // Sync alignment: 96-cycle hsync pulse and a short vsync pulse.
    for (int i = 0; i < 120; i++)
      drive(0, 0, 1'b0, !(i >= 10 && i < 106), !(i >= 50 && i < 52), 0, 0, 1'b0, 1'b0, 0, 0);

    // Reset mid-frame with outputs active.
    vec(165, 329, 1'b1, 1'b0, 73, 0, 1'b1, 1'b0, 2, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_oe", 32'(Place_OE), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    video_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vec(400, 200, 1'b1, 1'b0, 0, 30, 1'b0, 1'b1, 0, 1);
    vec(165, 329, 1'b1, 1'b0, 73, 0, 1'b1, 1'b0, 2, 0);

    for (int i = 0; i < 10 && (aq.size() > 0 || oq.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    if (aq.size() > 0 || oq.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d addr and %0d output expectations left", aq.size(), oq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_fetch.md
Name: grid_fetch

Overview:
- Upstream of the per-pixel colour lookup stage. Takes VGA raster coordinates and decides whether the current pixel falls inside the placement grid or the shooting grid.
- Issues the synchronous read address for the matching cell memory and returns the 2-bit cell state with the output-enable flags the colour stage consumes.
- Delays hsync/vsync by the same latency so colour and sync stay aligned at the VGA pins.

Parameters:
- GRID_N, 10, cells per grid side (rows = cols).
- CELL_PX, 32, pixel size of one cell; must be a power of two.
- PLACE_X0, 64, left pixel column of the placement grid.
- SHOOT_X0, 384, left pixel column of the shooting grid.
- GRID_Y0, 96, top pixel row of both grids.
- ADDR_W, 7, cell address width; must satisfy 2^ADDR_W >= GRID_N*GRID_N.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- pix_x  in  10  current raster column from the VGA timing generator.
- pix_y  in  10  current raster row.
- video_on  in  1  high inside the visible area.
- hsync_in  in  1  raw horizontal sync.
- vsync_in  in  1  raw vertical sync.
- Place_ADDR  out  ADDR_W  read address to the placement memory.
- Shoot_ADDR  out  ADDR_W  read address to the shooting memory.
- Place_RD_DATA  in  2  placement memory read data, valid 1 cycle after address.
- Shoot_RD_DATA  in  2  shooting memory read data, valid 1 cycle after address.
- Place_DATA  out  2  cell state to the colour stage.
- Shoot_DATA  out  2  cell state to the colour stage.
- Place_OE  out  1  pixel belongs to a placement-grid cell.
- Shoot_OE  out  1  pixel belongs to a shooting-grid cell.
- hsync_out  out  1  hsync delayed to match the data path.
- vsync_out  out  1  vsync delayed to match the data path.

Behaviour:
- Clock and reset: single clock domain; all flops reset asynchronously when rst_n = 0.
- Reset values: Place_ADDR and Shoot_ADDR = 0; Place_DATA and Shoot_DATA = 2'b00; Place_OE and Shoot_OE = 0; hsync_out and vsync_out = 1 (inactive).
- Stage 0 (registered at the first clk edge):
  - dx = pix_x - X0 and dy = pix_y - GRID_Y0, computed 10-bit unsigned.
  - An axis is in range when pix >= X0 and pix < X0 + GRID_N*CELL_PX; same rule for y. The comparison must not depend on unsigned wrap of dx/dy.
  - col = dx >> log2(CELL_PX), row = dy >> log2(CELL_PX).
  - addr = row*GRID_N + col, truncated to ADDR_W bits; range 0..99.
  - place_hit = video_on & x-in-range(PLACE_X0) & y-in-range; shoot_hit is the same test with SHOOT_X0.
  - Place_ADDR/Shoot_ADDR register the computed address when the corresponding hit is 1, otherwise 0.
- Stage 1 (second clk edge): memory data is now valid. Place_DATA <= Place_RD_DATA, Shoot_DATA <= Shoot_RD_DATA, Place_OE <= place_hit (delayed), Shoot_OE <= shoot_hit (delayed).
- When an OE is 0, the matching DATA output is forced to 2'b00.
- Latency: exactly 2 clk cycles from pix_x/pix_y/video_on/sync to every output. hsync/vsync pass through a 2-deep shift register.
- Mutual exclusion: Place_OE and Shoot_OE are never both 1. If the parameters overlap the regions, placement wins and Shoot_OE is forced to 0.
- Boundaries:
  - pix_x = X0 gives col 0.
  - pix_x = X0 + GRID_N*CELL_PX - 1 gives col GRID_N-1.
  - pix_x = X0 + GRID_N*CELL_PX is outside the grid.
  - pix_x < X0 is outside the grid, with no wrap into a large col.
- Blanking: video_on = 0 clears both hits regardless of coordinates.
- Reset mid-frame: outputs return to reset values immediately. After release, the first valid output appears 2 cycles after the first sampled input; there is no frame resynchronisation.

Optional Feature:
- Macro: GRID_LINES_EN.
- Defined: pixels whose in-cell x offset or y offset is 0 force both hits to 0. The colour stage then paints background and the grid shows 1-pixel cell borders. Latency is unchanged.
- Undefined: border pixels belong to their cell; no border logic is synthesised.

Decomposition:
- Package battleship_pkg holds:
  - GRID_N, CELL_PX, ADDR_W.
  - The cell-state encoding constants: 2'b00 no ship/no hit, 2'b01 no ship/hit, 2'b10 ship/no hit, 2'b11 ship/hit.
  - The VGA visible width and height constants.
- Sub-module grid_locator: one axis, combinational. Inputs are pix and origin; outputs are index and in_range (plus on_border when GRID_LINES_EN is defined).
- grid_fetch instantiates grid_locator three times: placement x, shooting x, shared y.

Test Plan:
- Reset: hold rst_n = 0 with active coordinates -> all outputs at reset values; both OE = 0; hsync_out = vsync_out = 1.
- Cell mapping: pix_x = 64+32*3+5, pix_y = 96+32*7+9, video_on = 1, memory model returns 2'b10 at addr 73 -> Place_ADDR = 73 one cycle later; Place_OE = 1, Place_DATA = 2'b10 two cycles later; Shoot_OE = 0.
- Right/bottom edges:
  - pix_x = 383 -> placement col 9 (SHOOT_X0 is its own origin).
  - pix_x = 384 -> Shoot_ADDR col 0, Shoot_OE = 1.
  - pix_x = 704 -> both OE = 0.
  - pix_y = 416 -> both OE = 0.
- Blanking and low side: video_on = 0 inside the grid -> OE = 0, DATA = 0. pix_x = 63 -> OE = 0, with no wrap to a high address.
- Sync alignment: pulse hsync_in low for 96 cycles -> hsync_out low for exactly the same 96 cycles, shifted by 2.
- GRID_LINES_EN build: pix_x = 96 (cell boundary) -> Place_OE = 0; pix_x = 97 -> Place_OE = 1. Default build: pix_x = 96 -> Place_OE = 1.
